// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: data width, base opcodes and the
// fetch state encoding used by the instruction fetch stage.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LD   = 7'b0000011;
    localparam logic [6:0] OPC_S    = 7'b0100011;
    localparam logic [6:0] OPC_B    = 7'b1100011;
    localparam logic [6:0] OPC_J    = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        OUT
    } fetch_state_t;

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a
// req/gnt/rvalid port and hands a single buffered instruction to decode.
module ifetch_unit #(
    parameter int unsigned     XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            imem_err_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic [XLEN-1:0] instr_pc4_o,
    output logic            fetch_err_o,
    output logic            misalign_o,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i
);
    import riscv_pkg::*;

    fetch_state_t    state_q, state_d;
    logic            run_q;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic            err_q, err_d;
    logic            mis_q, mis_d;
    logic            handshake;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] next_pc;

    // A misaligned PC resumes at the following aligned word.
    assign seq_pc    = {pc_q[XLEN-1:2], 2'b00} + XLEN'(4);
    assign handshake = (state_q == OUT) && instr_ready_i;
    assign next_pc   = redirect_i ? redirect_pc_i : seq_pc;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        err_d   = err_q;
        mis_d   = mis_q;
        case (state_q)
            REQ: begin
                if (run_q && imem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = OUT;
                    instr_d = imem_err_i ? 32'h0 : imem_rdata_i;
                    ipc_d   = pc_q;
                    err_d   = imem_err_i;
                    mis_d   = 1'b0;
                end
            end
            OUT: begin
                if (handshake) begin
                    pc_d    = next_pc;
                    instr_d = 32'h0;
                    err_d   = 1'b0;
                    if (next_pc[1:0] == 2'b00) begin
                        state_d = REQ;
                        ipc_d   = '0;
                        mis_d   = 1'b0;
                    end else begin
                        // Never fetch from a misaligned target; present a trap entry.
                        ipc_d = next_pc;
                        mis_d = 1'b1;
                    end
                end
            end
            default: state_d = REQ;
        endcase
    end

    // run_q keeps the request low for the first cycle out of reset, so the
    // request stays a pure function of registered state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= REQ;
            run_q   <= 1'b0;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            ipc_q   <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    assign imem_req_o    = (state_q == REQ) && run_q;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = (state_q == OUT);
    assign instr_o       = instr_q;
    assign instr_pc_o    = ipc_q;
    assign instr_pc4_o   = ipc_q + XLEN'(4);
    assign fetch_err_o   = err_q;
    assign misalign_o    = mis_q;

`ifndef SYNTHESIS
    a_rvalid_in_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_rvalid_i |-> (state_q == WAIT));
    a_gnt_with_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_gnt_i |-> imem_req_o);
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a per-cycle vector table for the main
// fetch flow plus hand-written reset and handshake sequences.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        fetch_err;
    logic        misalign;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_gnt_i   (imem_gnt),
        .imem_rvalid_i(imem_rvalid),
        .imem_rdata_i (imem_rdata),
        .imem_err_i   (imem_err),
        .instr_valid_o(instr_valid),
        .instr_ready_i(instr_ready),
        .instr_o      (instr),
        .instr_pc_o   (instr_pc),
        .instr_pc4_o  (instr_pc4),
        .fetch_err_o  (fetch_err),
        .misalign_o   (misalign),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc)
    );

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic        rdy;
        logic        red;
        logic [31:0] rpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] einstr;
        logic [31:0] epc;
        logic        eerr;
        logic        emis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic g, input logic rv, input logic [31:0] rd, input logic e,
                       input logic rdy, input logic red, input logic [31:0] rpc,
                       input logic ereq, input logic [31:0] eaddr, input logic ev,
                       input logic [31:0] ei, input logic [31:0] epc, input logic ee,
                       input logic em);
        vec_t v;
        v.gnt = g; v.rv = rv; v.rdata = rd; v.err = e; v.rdy = rdy; v.red = red; v.rpc = rpc;
        v.ereq = ereq; v.eaddr = eaddr; v.evalid = ev; v.einstr = ei; v.epc = epc;
        v.eerr = ee; v.emis = em;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ereq, input logic [31:0] eaddr,
                           input logic ev, input logic [31:0] ei, input logic [31:0] epc,
                           input logic ee, input logic em);
        chk({tag, " req"},   32'(imem_req), 32'(ereq));
        chk({tag, " addr"},  imem_addr, eaddr);
        chk({tag, " valid"}, 32'(instr_valid), 32'(ev));
        chk({tag, " instr"}, instr, ei);
        chk({tag, " pc"},    instr_pc, epc);
        chk({tag, " err"},   32'(fetch_err), 32'(ee));
        chk({tag, " mis"},   32'(misalign), 32'(em));
        if (ev) chk({tag, " pc4"}, instr_pc4, epc + 32'd4);
    endtask

    task automatic idle_inputs();
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; imem_err = 0;
        instr_ready = 0; redirect = 0; redirect_pc = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        rst_n = 0;
        idle_inputs();

        //   g rv rdata         e rdy red rpc           | req addr          v instr         pc            fe mis
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,          1, 32'h0,         0, 32'h0,        32'h0,        0, 0);
        add(0, 1, 32'h00500093, 0, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h0,        0, 0);
        add(0, 0, 32'h0,        0, 1, 0, 32'h0,          0, 32'h0,         1, 32'h00500093, 32'h0,        0, 0);
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,          1, 32'h4,         0, 32'h0,        32'h0,        0, 0);
        add(0, 1, 32'h00100113, 0, 0, 0, 32'h0,          0, 32'h4,         0, 32'h0,        32'h0,        0, 0);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 32'h4,         1, 32'h00100113, 32'h4,        0, 0);
        add(0, 0, 32'h0,        0, 0, 1, 32'h100,        0, 32'h4,         1, 32'h00100113, 32'h4,        0, 0);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 32'h4,         1, 32'h00100113, 32'h4,        0, 0);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 32'h4,         1, 32'h00100113, 32'h4,        0, 0);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 32'h4,         1, 32'h00100113, 32'h4,        0, 0);
        add(0, 0, 32'h0,        0, 1, 0, 32'h0,          0, 32'h4,         1, 32'h00100113, 32'h4,        0, 0);
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,          1, 32'h8,         0, 32'h0,        32'h0,        0, 0);
        add(0, 1, 32'h00000013, 0, 0, 0, 32'h0,          0, 32'h8,         0, 32'h0,        32'h0,        0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 32'h10,         0, 32'h8,         1, 32'h00000013, 32'h8,        0, 0);
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,          1, 32'h10,        0, 32'h0,        32'h0,        0, 0);
        add(0, 1, 32'h0f00006f, 0, 0, 0, 32'h0,          0, 32'h10,        0, 32'h0,        32'h0,        0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 32'h100,        0, 32'h10,        1, 32'h0f00006f, 32'h10,       0, 0);
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,          1, 32'h100,       0, 32'h0,        32'h0,        0, 0);
        add(0, 1, 32'h00208067, 0, 0, 0, 32'h0,          0, 32'h100,       0, 32'h0,        32'h0,        0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 32'h102,        0, 32'h100,       1, 32'h00208067, 32'h100,      0, 0);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 32'h102,       1, 32'h0,        32'h102,      0, 1);
        add(0, 0, 32'h0,        0, 1, 0, 32'h0,          0, 32'h102,       1, 32'h0,        32'h102,      0, 1);
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,          1, 32'h104,       0, 32'h0,        32'h0,        0, 0);
        add(0, 1, 32'h00000013, 0, 0, 0, 32'h0,          0, 32'h104,       0, 32'h0,        32'h0,        0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 32'h20,         0, 32'h104,       1, 32'h00000013, 32'h104,      0, 0);
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,          1, 32'h20,        0, 32'h0,        32'h0,        0, 0);
        add(0, 1, 32'hdeadbeef, 1, 0, 0, 32'h0,          0, 32'h20,        0, 32'h0,        32'h0,        0, 0);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 32'h20,        1, 32'h0,        32'h20,       1, 0);
        add(0, 0, 32'h0,        0, 1, 0, 32'h0,          0, 32'h20,        1, 32'h0,        32'h20,       1, 0);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,          1, 32'h24,        0, 32'h0,        32'h0,        0, 0);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,          1, 32'h24,        0, 32'h0,        32'h0,        0, 0);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,          1, 32'h24,        0, 32'h0,        32'h0,        0, 0);
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,          1, 32'h24,        0, 32'h0,        32'h0,        0, 0);
        add(0, 1, 32'h00400093, 0, 0, 0, 32'h0,          0, 32'h24,        0, 32'h0,        32'h0,        0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 32'hfffffffc,   0, 32'h24,        1, 32'h00400093, 32'h24,       0, 0);
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,          1, 32'hfffffffc,  0, 32'h0,        32'h0,        0, 0);
        add(0, 1, 32'h00000013, 0, 0, 0, 32'h0,          0, 32'hfffffffc,  0, 32'h0,        32'h0,        0, 0);
        add(0, 0, 32'h0,        0, 1, 0, 32'h0,          0, 32'hfffffffc,  1, 32'h00000013, 32'hfffffffc, 0, 0);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,          1, 32'h0,         0, 32'h0,        32'h0,        0, 0);

        // Reset state
        repeat (3) @(negedge clk);
        #1 chk_all("reset", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        $display("reset: req=%0d addr=%08h valid=%0d", imem_req, imem_addr, instr_valid);
        rst_n = 1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            imem_gnt    = vecs[i].gnt;
            imem_rvalid = vecs[i].rv;
            imem_rdata  = vecs[i].rdata;
            imem_err    = vecs[i].err;
            instr_ready = vecs[i].rdy;
            redirect    = vecs[i].red;
            redirect_pc = vecs[i].rpc;
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].ereq, vecs[i].eaddr, vecs[i].evalid,
                    vecs[i].einstr, vecs[i].epc, vecs[i].eerr, vecs[i].emis);
            $display("vec%0d: req=%0d addr=%08h valid=%0d instr=%08h pc=%08h err=%0d mis=%0d",
                     i, imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err, misalign);
        end

        // Reset asserted while a response is outstanding
        @(negedge clk);
        idle_inputs();
        imem_gnt = 1;
        @(negedge clk);
        imem_gnt = 0;
        #1 chk("midrst wait req", 32'(imem_req), 32'd0);
        #2 rst_n = 0;
        #1 chk_all("midrst async", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        $display("midrst: req=%0d valid=%0d", imem_req, instr_valid);
        repeat (2) @(negedge clk);
        rst_n = 1;

        seen = 0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            #1 if (imem_req) seen = 1;
        end
        chk("post-reset req seen", 32'(seen), 32'd1);
        chk("post-reset addr", imem_addr, 32'h0);
        chk("post-reset valid", 32'(instr_valid), 32'd0);
        imem_gnt = 1;
        @(negedge clk);
        imem_gnt = 0;
        imem_rvalid = 1;
        imem_rdata = 32'h00a00093;
        @(negedge clk);
        imem_rvalid = 0;
        seen = 0;
        for (int c = 0; c < 5 && !seen; c++) begin
            #1 if (instr_valid) seen = 1;
            if (!seen) @(negedge clk);
        end
        chk("post-reset valid seen", 32'(seen), 32'd1);
        chk("post-reset instr", instr, 32'h00a00093);
        chk("post-reset pc", instr_pc, 32'h0);
        instr_ready = 1;
        @(negedge clk);
        instr_ready = 0;
        #1 chk("post-reset next addr", imem_addr, 32'h4);
        chk("post-reset next req", 32'(imem_req), 32'd1);
        $display("post-reset: addr=%08h req=%0d", imem_addr, imem_req);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage directly upstream of the decoder/controller. Holds the PC and issues word requests to instruction memory over a req/gnt/rvalid handshake. Presents one fetched instruction at a time to decode over a valid/ready handshake. Selects the next PC from PC+4 or the control-transfer target (jal/jalr/taken branch) of the instruction retiring that cycle.

Parameters:
XLEN, 32, PC and address width
RESET_PC, 32'h0000_0000, PC loaded on reset (must be 4-byte aligned)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, asynchronous, active-low
imem_req_o  output  1  instruction memory request
imem_addr_o  output  XLEN  request word address (= pc_q)
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response valid; at most one outstanding
imem_rdata_i  input  32  response instruction word
imem_err_i  input  1  access fault, qualified by imem_rvalid_i
instr_valid_o  output  1  instruction buffer valid
instr_ready_i  input  1  decode/execute consumes buffer this cycle
instr_o  output  32  buffered instruction
instr_pc_o  output  XLEN  PC of buffered instruction
instr_pc4_o  output  XLEN  instr_pc_o + 4 (jal/jalr link value)
fetch_err_o  output  1  buffered entry is an access fault
misalign_o  output  1  buffered entry is a misaligned-target trap
redirect_i  input  1  retiring instruction takes a control transfer
redirect_pc_i  input  XLEN  transfer target (jalr bit0 already cleared)

Behaviour:
- Reset (async, rst_ni=0): state=REQ, pc_q=RESET_PC, buffer cleared; instr_valid_o=0, instr_o=0, instr_pc_o=0, fetch_err_o=0, misalign_o=0, imem_req_o=0 while in reset.
- FSM states REQ, WAIT, OUT; imem_req_o driven from state only (no combinational path from any input).
- REQ: imem_req_o=1, imem_addr_o=pc_q. imem_gnt_i=1 -> WAIT. Otherwise stay in REQ with address held stable.
- WAIT: imem_req_o=0. imem_rvalid_i=1 -> load buffer {rdata, pc_q, err}, go to OUT. On err, instr_o=0 and fetch_err_o=1.
- OUT: instr_valid_o=1, all buffer outputs stable until consumed. Handshake is instr_valid_o && instr_ready_i.
  - On handshake: next_pc = redirect_i ? redirect_pc_i : pc_q+4, pc_q<=next_pc, clear buffer.
  - If next_pc[1:0]==0 -> REQ.
  - If next_pc[1]==1 -> stay in OUT with buffer {instr=0, pc=next_pc, misalign_o=1}; no memory request is issued.
- redirect_i/redirect_pc_i are ignored unless the handshake occurs that cycle.
- A misaligned or faulting entry is consumed like any other. The environment is responsible for redirecting to a trap vector; otherwise fetch resumes at pc+4 (aligned down: pc_q<=(pc&~3)+4).
- Latency: with gnt in the REQ cycle (n) and rvalid at n+1, instr_valid_o=1 at n+2. Best-case throughput is 1 instruction per 3 cycles.
- pc+4 wraps modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000), no flag.
- rvalid outside WAIT, or gnt outside REQ: ignored. Assertion fires in simulation.
- Reset asserted mid-transaction (in WAIT) drops the outstanding response. After reset release the memory side must not return the stale rvalid; the bench enforces this.

Decomposition:
- Shared package riscv_pkg: XLEN, opcode localparams (R/I/LD/S/B/J/JALR), NOP constant 32'h0000_0013, fetch_state_t enum {REQ, WAIT, OUT}.
- Single module; no sub-module. The next-PC mux and adder stay inline.

Test Plan:
- Reset release, memory grants immediately, rvalid next cycle with 32'h00500093 -> instr_valid_o=1 two cycles after the first request, instr_pc_o=0, instr_pc4_o=4. After ready, the next request addr=4.
- Back-pressure: hold instr_ready_i=0 for 5 cycles in OUT -> instr_o and instr_pc_o stable, imem_req_o=0 throughout. The next request is issued only after ready.
- Redirect: retire the instr at pc=0x10 with redirect_i=1, redirect_pc_i=0x100 -> next imem_addr_o=0x100. The same redirect with instr_ready_i=0 -> ignored, addr unchanged.
- Misaligned target 0x102 -> no imem_req_o; next entry has misalign_o=1, instr_pc_o=0x102.
- Access fault: rvalid with imem_err_i=1 at pc=0x20 -> fetch_err_o=1, instr_o=0. After consume, the next fetch addr=0x24.
- Delayed grant (gnt after 3 cycles) and wrap at pc=0xFFFF_FFFC -> address held stable while waiting; the next addr after 0xFFFF_FFFC is 0x0000_0000.
